register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- 32 x 32-bit general-purpose register file for the CS147DV datapath: one synchronous write port and two registered read ports.
- Sits directly upstream of the operand-select muxes and the ALU.
- Read selection is built from the team's structural MUX32_32x1 cell, one instance per read port.
- Storage, write decode, same-address bypass, reset and read-valid sequencing are local to this block.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH = 32
ZERO_REG, 1, when 1, R0 is hardwired to zero and writes to it are discarded

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
READ  input  1  read request; samples ADDR_R1/ADDR_R2 on this edge
WRITE  input  1  write request; writes DATA_W to ADDR_W on this edge
ADDR_R1  input  ADDR_WIDTH  read port 1 address
ADDR_R2  input  ADDR_WIDTH  read port 2 address
ADDR_W  input  ADDR_WIDTH  write address
DATA_W  input  DATA_WIDTH  write data
DATA_R1  output  DATA_WIDTH  registered read data, port 1
DATA_R2  output  DATA_WIDTH  registered read data, port 2
RD_VALID  output  1  high for exactly one cycle after each accepted READ

Behaviour:
- Reset:
  - RST=1 asynchronously clears all 32 registers, DATA_R1, DATA_R2 and RD_VALID to 0.
  - Reset takes effect immediately, independent of CLK, and overrides any READ or WRITE in the same cycle.
  - While RST is high, no writes or reads are performed and all outputs remain 0.
  - First operation is accepted on the first rising CLK edge with RST=0.
- Write, on rising edge with WRITE=1:
  - REG[ADDR_W] <= DATA_W.
  - If ZERO_REG=1 and ADDR_W=0, the write is discarded.
  - WRITE=0 leaves all registers unchanged.
- Read, on rising edge with READ=1:
  - DATA_R1 <= REG[ADDR_R1] and DATA_R2 <= REG[ADDR_R2]; RD_VALID <= 1.
  - Latency is 1 cycle: data is valid in the cycle after READ is sampled, coincident with RD_VALID.
- Hold:
  - READ=0: DATA_R1/DATA_R2 hold their last value; RD_VALID <= 0.
  - Back-to-back READs keep RD_VALID high continuously.
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 regardless of stored contents or same-cycle writes.
- Simultaneous READ and WRITE to the same address (write-first):
  - The read port returns DATA_W, not the old contents.
  - Applies independently per port; both ports may bypass in the same cycle.
  - No bypass when ADDR_W=0 and ZERO_REG=1.
- Simultaneous READ and WRITE to different addresses: the read returns the pre-write contents; the write lands normally.
- Both read ports may address the same register; both return identical data.
- Widths: no arithmetic is performed. Addresses are used unsigned and in full; there is no wrap or truncation because 2**ADDR_WIDTH equals the register count.
- X-handling: READ/WRITE are treated as 0 only while RST=1. Outside reset, X on a control input is a verification error, not a defined behaviour.

Test Plan:
- Reset: assert RST mid-cycle after writing R5=0xDEADBEEF -> DATA_R1/DATA_R2/RD_VALID go to 0 without a clock edge; after release, READ R5 returns 0x00000000.
- Write then read: WRITE R1=0x00000011, R31=0xFFFFFFFF; next cycle READ ADDR_R1=1, ADDR_R2=31 -> one cycle later DATA_R1=0x00000011, DATA_R2=0xFFFFFFFF, RD_VALID=1 for one cycle.
- Zero register: WRITE R0=0x12345678 then READ both ports at 0 -> DATA_R1=DATA_R2=0x00000000.
- Write-first bypass: R7 holds 0xAAAA0000; same edge WRITE R7=0x5555FFFF and READ ADDR_R1=7, ADDR_R2=8 -> DATA_R1=0x5555FFFF, DATA_R2=old R8.
- Hold: READ R3=0x00000003, then three idle cycles while writing R3=0x00000009 -> DATA_R1 stays 0x00000003 and RD_VALID=0 until the next READ.
- Sweep: write REG[i]=i*0x01010101 for i=1..31, then read all pairs (i, 31-i) -> every value matches; R0 reads 0.

Source files
------------

// File: rtl/MUX32_32x1.sv
// Purpose: 32-to-1 word selector used as the read-port select cell.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows select and inputs continuously.
module MUX32_32x1 #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 5
) (
  input  logic [SEL_WIDTH-1:0]                   sel,
  input  logic [2**SEL_WIDTH-1:0][WIDTH-1:0]     din,
  output logic [WIDTH-1:0]                       dout
);

  // Select one word from the flattened input bank.
  always_comb begin
    dout = din[sel];
  end

endmodule

// File: rtl/register_file_2r1w.sv
// Purpose: 32x32 register file, one write port and two registered read ports, write-first bypass.
// Latency: read data and RD_VALID appear one cycle after READ is sampled; writes land on the same edge.
// Backpressure: none; every READ/WRITE is accepted on the edge it is presented.
module register_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0] regs;
  logic [DATA_WIDTH-1:0]           mux_r1;
  logic [DATA_WIDTH-1:0]           mux_r2;
  logic [DATA_WIDTH-1:0]           rd1_next;
  logic [DATA_WIDTH-1:0]           rd2_next;
  logic                            zero_en;
  logic                            wr_en;

  assign zero_en = (ZERO_REG != 0);

  // A write to R0 is dropped entirely when R0 is hardwired, so it also never bypasses.
  assign wr_en = WRITE && !(zero_en && (ADDR_W == '0));

  // Register storage: async clear, single write port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs <= '0;
    end else if (wr_en) begin
      regs[ADDR_W] <= DATA_W;
    end
  end

  MUX32_32x1 #(
    .WIDTH     (DATA_WIDTH),
    .SEL_WIDTH (ADDR_WIDTH)
  ) u_mux_r1 (
    .sel  (ADDR_R1),
    .din  (regs),
    .dout (mux_r1)
  );

  MUX32_32x1 #(
    .WIDTH     (DATA_WIDTH),
    .SEL_WIDTH (ADDR_WIDTH)
  ) u_mux_r2 (
    .sel  (ADDR_R2),
    .din  (regs),
    .dout (mux_r2)
  );

  // Port 1 read data: stored value, overridden by same-edge write, forced zero for hardwired R0.
  always_comb begin
    rd1_next = mux_r1;
    if (wr_en && (ADDR_W == ADDR_R1)) begin
      rd1_next = DATA_W;
    end
    if (zero_en && (ADDR_R1 == '0)) begin
      rd1_next = '0;
    end
  end

  // Port 2 read data: same selection rules as port 1, evaluated independently.
  always_comb begin
    rd2_next = mux_r2;
    if (wr_en && (ADDR_W == ADDR_R2)) begin
      rd2_next = DATA_W;
    end
    if (zero_en && (ADDR_R2 == '0)) begin
      rd2_next = '0;
    end
  end

  // Output registers: capture on READ, hold otherwise; RD_VALID pulses per accepted READ.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATA_R1  <= '0;
      DATA_R2  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= READ;
      if (READ) begin
        DATA_R1 <= rd1_next;
        DATA_R2 <= rd2_next;
      end
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Purpose: directed self-checking bench for register_file_2r1w.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is fixed-length.
module tb_register_file_2r1w;

  logic        CLK;
  logic        RST;
  logic        READ;
  logic        WRITE;
  logic [4:0]  ADDR_R1;
  logic [4:0]  ADDR_R2;
  logic [4:0]  ADDR_W;
  logic [31:0] DATA_W;
  logic [31:0] DATA_R1;
  logic [31:0] DATA_R2;
  logic        RD_VALID;

  int errors = 0;
  int checks = 0;

  register_file_2r1w #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .ZERO_REG   (1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .READ     (READ),
    .WRITE    (WRITE),
    .ADDR_R1  (ADDR_R1),
    .ADDR_R2  (ADDR_R2),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DATA_R1  (DATA_R1),
    .DATA_R2  (DATA_R2),
    .RD_VALID (RD_VALID)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance past the next rising edge; inputs are changed and outputs sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    WRITE = 1'b1; ADDR_W = a; DATA_W = d;
    tick();
    WRITE = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
    READ = 1'b1; ADDR_R1 = a1; ADDR_R2 = a2;
    tick();
    READ = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (DATA_R1 !== 32'h0) begin errors++; $display("FAIL reset_r1 got=%h exp=%h", DATA_R1, 32'h0); end
    checks++; if (DATA_R2 !== 32'h0) begin errors++; $display("FAIL reset_r2 got=%h exp=%h", DATA_R2, 32'h0); end
    checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", RD_VALID); end
    RST = 1'b0;
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd5);
    checks++; if (DATA_R1 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_r5 got=%h exp=%h", DATA_R1, 32'hDEADBEEF); end
    checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL pre_reset_vld got=%b exp=1", RD_VALID); end
    // Assert reset mid-cycle, well away from either clock edge.
    #2 RST = 1'b1;
    #1;
    checks++; if (DATA_R1 !== 32'h0) begin errors++; $display("FAIL async_reset_r1 got=%h exp=%h", DATA_R1, 32'h0); end
    checks++; if (DATA_R2 !== 32'h0) begin errors++; $display("FAIL async_reset_r2 got=%h exp=%h", DATA_R2, 32'h0); end
    checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL async_reset_vld got=%b exp=0", RD_VALID); end
    // Requests during reset must be ignored.
    READ = 1'b1; WRITE = 1'b1; ADDR_R1 = 5'd5; ADDR_R2 = 5'd6; ADDR_W = 5'd6; DATA_W = 32'h66666666;
    tick();
    checks++; if (RD_VALID !== 1'b0 || DATA_R2 !== 32'h0) begin errors++; $display("FAIL reset_override got=%b/%h exp=0/%h", RD_VALID, DATA_R2, 32'h0); end
    READ = 1'b0; WRITE = 1'b0;
    RST = 1'b0;
    do_read(5'd5, 5'd6);
    checks++; if (DATA_R1 !== 32'h0) begin errors++; $display("FAIL post_reset_r5 got=%h exp=%h", DATA_R1, 32'h0); end
    checks++; if (DATA_R2 !== 32'h0) begin errors++; $display("FAIL post_reset_r6 got=%h exp=%h", DATA_R2, 32'h0); end
    checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL post_reset_vld got=%b exp=1", RD_VALID); end
  endtask

  task automatic test_write_read();
    do_write(5'd1, 32'h00000011);
    do_write(5'd31, 32'hFFFFFFFF);
    do_read(5'd1, 5'd31);
    checks++; if (DATA_R1 !== 32'h00000011) begin errors++; $display("FAIL wr_rd_r1 got=%h exp=%h", DATA_R1, 32'h00000011); end
    checks++; if (DATA_R2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL wr_rd_r31 got=%h exp=%h", DATA_R2, 32'hFFFFFFFF); end
    checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL wr_rd_vld got=%b exp=1", RD_VALID); end
    tick();
    checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL wr_rd_vld_drop got=%b exp=0", RD_VALID); end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'h12345678);
    do_read(5'd0, 5'd0);
    checks++; if (DATA_R1 !== 32'h0) begin errors++; $display("FAIL zero_r1 got=%h exp=%h", DATA_R1, 32'h0); end
    checks++; if (DATA_R2 !== 32'h0) begin errors++; $display("FAIL zero_r2 got=%h exp=%h", DATA_R2, 32'h0); end
    // Same-edge write to R0 must not bypass into the read.
    READ = 1'b1; WRITE = 1'b1; ADDR_R1 = 5'd0; ADDR_R2 = 5'd1; ADDR_W = 5'd0; DATA_W = 32'hCAFEF00D;
    tick();
    READ = 1'b0; WRITE = 1'b0;
    checks++; if (DATA_R1 !== 32'h0) begin errors++; $display("FAIL zero_no_bypass got=%h exp=%h", DATA_R1, 32'h0); end
    checks++; if (DATA_R2 !== 32'h00000011) begin errors++; $display("FAIL zero_side_r1 got=%h exp=%h", DATA_R2, 32'h00000011); end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 32'hAAAA0000);
    do_write(5'd8, 32'h88888888);
    READ = 1'b1; WRITE = 1'b1; ADDR_R1 = 5'd7; ADDR_R2 = 5'd8; ADDR_W = 5'd7; DATA_W = 32'h5555FFFF;
    tick();
    READ = 1'b0; WRITE = 1'b0;
    checks++; if (DATA_R1 !== 32'h5555FFFF) begin errors++; $display("FAIL bypass_r1 got=%h exp=%h", DATA_R1, 32'h5555FFFF); end
    checks++; if (DATA_R2 !== 32'h88888888) begin errors++; $display("FAIL bypass_other got=%h exp=%h", DATA_R2, 32'h88888888); end
    // Both ports bypass together.
    do_write(5'd9, 32'h00000099);
    READ = 1'b1; WRITE = 1'b1; ADDR_R1 = 5'd9; ADDR_R2 = 5'd9; ADDR_W = 5'd9; DATA_W = 32'h0BADBEEF;
    tick();
    READ = 1'b0; WRITE = 1'b0;
    checks++; if (DATA_R1 !== 32'h0BADBEEF) begin errors++; $display("FAIL bypass_both_r1 got=%h exp=%h", DATA_R1, 32'h0BADBEEF); end
    checks++; if (DATA_R2 !== 32'h0BADBEEF) begin errors++; $display("FAIL bypass_both_r2 got=%h exp=%h", DATA_R2, 32'h0BADBEEF); end
    // Different-address write returns old data for the read; write still lands.
    READ = 1'b1; WRITE = 1'b1; ADDR_R1 = 5'd8; ADDR_R2 = 5'd7; ADDR_W = 5'd10; DATA_W = 32'h10101010;
    tick();
    READ = 1'b0; WRITE = 1'b0;
    checks++; if (DATA_R1 !== 32'h88888888) begin errors++; $display("FAIL diff_addr_r8 got=%h exp=%h", DATA_R1, 32'h88888888); end
    do_read(5'd7, 5'd10);
    checks++; if (DATA_R1 !== 32'h5555FFFF) begin errors++; $display("FAIL bypass_landed got=%h exp=%h", DATA_R1, 32'h5555FFFF); end
    checks++; if (DATA_R2 !== 32'h10101010) begin errors++; $display("FAIL diff_addr_landed got=%h exp=%h", DATA_R2, 32'h10101010); end
  endtask

  task automatic test_hold();
    do_write(5'd3, 32'h00000003);
    do_read(5'd3, 5'd3);
    checks++; if (DATA_R1 !== 32'h00000003) begin errors++; $display("FAIL hold_first got=%h exp=%h", DATA_R1, 32'h00000003); end
    WRITE = 1'b1; ADDR_W = 5'd3; DATA_W = 32'h00000009;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (DATA_R1 !== 32'h00000003) begin errors++; $display("FAIL hold_data_%0d got=%h exp=%h", k, DATA_R1, 32'h00000003); end
      checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL hold_vld_%0d got=%b exp=0", k, RD_VALID); end
    end
    WRITE = 1'b0;
    do_read(5'd3, 5'd3);
    checks++; if (DATA_R1 !== 32'h00000009) begin errors++; $display("FAIL hold_reread got=%h exp=%h", DATA_R1, 32'h00000009); end
    checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL hold_reread_vld got=%b exp=1", RD_VALID); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1;
    logic [31:0] e2;
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h01010101);
    end
    READ = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ADDR_R1 = 5'(i);
      ADDR_R2 = 5'(31 - i);
      tick();
      e1 = 32'(i) * 32'h01010101;
      e2 = 32'(31 - i) * 32'h01010101;
      checks++; if (DATA_R1 !== e1) begin errors++; $display("FAIL sweep_r1_%0d got=%h exp=%h", i, DATA_R1, e1); end
      checks++; if (DATA_R2 !== e2) begin errors++; $display("FAIL sweep_r2_%0d got=%h exp=%h", i, DATA_R2, e2); end
      checks++; if (RD_VALID !== 1'b1) begin errors++; $display("FAIL sweep_vld_%0d got=%b exp=1", i, RD_VALID); end
    end
    READ = 1'b0;
    tick();
    checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL sweep_vld_end got=%b exp=0", RD_VALID); end
  endtask

  initial begin
    RST = 1'b1; READ = 1'b0; WRITE = 1'b0;
    ADDR_R1 = '0; ADDR_R2 = '0; ADDR_W = '0; DATA_W = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
